// File: rtl/msrh_pkg.sv
// msrh_pkg: shared types and constants for the L2 request arbiter slice.
//   l2_cmd_t       : L2 command encoding (LOAD / STORE / EVICT)
//   L2_REQ_*       : requester index of each L2 client
//   rr_next()      : round-robin pointer advance helper
package msrh_pkg;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      STORE = 2'd1,
      EVICT = 2'd2
   } l2_cmd_t;

   localparam int L2_REQ_IC  = 0;
   localparam int L2_REQ_L1D = 1;
   localparam int L2_REQ_PTW = 2;

   // Pointer that follows the winner, wrapping at n.
   function automatic int rr_next(input int ptr, input int n);
      return (ptr + 1 >= n) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/msrh_l2_req_arbiter_if.sv
// msrh_l2_req_arbiter_if: bundle of the per-client request/response signals
// and the single L2 request/response port.
//   slave  modport : arbiter side (takes client requests and L2 responses)
//   master modport : environment side (clients + L2)
// Signals:
//   i_req_valid/cmd/addr/tag/data, o_req_ready : per-client request channel
//   o_l2_req_valid/cmd/addr/data/tag, i_l2_req_ready : L2 request channel
//   i_l2_resp_valid/tag/data                   : L2 response channel
//   o_resp_valid/tag/data                      : response routed to clients
//   o_perf_grant_cnt                           : per-client grant counters
interface msrh_l2_req_arbiter_if #(
   parameter int REQ_NUM = 3,
   parameter int ADDR_W  = 56,
   parameter int DATA_W  = 512,
   parameter int TAG_W   = 4
);
   localparam int ID_W = $clog2(REQ_NUM);

   logic [REQ_NUM-1:0]              i_req_valid;
   logic [REQ_NUM-1:0]              o_req_ready;
   logic [REQ_NUM-1:0][1:0]         i_req_cmd;
   logic [REQ_NUM-1:0][ADDR_W-1:0]  i_req_addr;
   logic [REQ_NUM-1:0][TAG_W-1:0]   i_req_tag;
   logic [REQ_NUM-1:0][DATA_W-1:0]  i_req_data;

   logic                            o_l2_req_valid;
   logic                            i_l2_req_ready;
   logic [1:0]                      o_l2_req_cmd;
   logic [ADDR_W-1:0]               o_l2_req_addr;
   logic [DATA_W-1:0]               o_l2_req_data;
   logic [ID_W+TAG_W-1:0]           o_l2_req_tag;

   logic                            i_l2_resp_valid;
   logic [ID_W+TAG_W-1:0]           i_l2_resp_tag;
   logic [DATA_W-1:0]               i_l2_resp_data;

   logic [REQ_NUM-1:0]              o_resp_valid;
   logic [TAG_W-1:0]                o_resp_tag;
   logic [DATA_W-1:0]               o_resp_data;

   logic [REQ_NUM-1:0][31:0]        o_perf_grant_cnt;

   modport slave (
      input  i_req_valid, i_req_cmd, i_req_addr, i_req_tag, i_req_data,
      output o_req_ready,
      output o_l2_req_valid, o_l2_req_cmd, o_l2_req_addr, o_l2_req_data, o_l2_req_tag,
      input  i_l2_req_ready,
      input  i_l2_resp_valid, i_l2_resp_tag, i_l2_resp_data,
      output o_resp_valid, o_resp_tag, o_resp_data,
      output o_perf_grant_cnt
   );

   modport master (
      output i_req_valid, i_req_cmd, i_req_addr, i_req_tag, i_req_data,
      input  o_req_ready,
      input  o_l2_req_valid, o_l2_req_cmd, o_l2_req_addr, o_l2_req_data, o_l2_req_tag,
      output i_l2_req_ready,
      output i_l2_resp_valid, i_l2_resp_tag, i_l2_resp_data,
      input  o_resp_valid, o_resp_tag, o_resp_data,
      input  o_perf_grant_cnt
   );

endinterface

// File: rtl/msrh_rr_arbiter.sv
// msrh_rr_arbiter: purely combinational round-robin picker.
//   eligible : per-requester eligibility
//   rr_ptr   : first index to search from (register lives in the parent)
//   grant    : one-hot winner (all zero when nothing is eligible)
//   winner   : encoded winner (0 when nothing is eligible)
module msrh_rr_arbiter #(
   parameter  int REQ_NUM = 3,
   localparam int ID_W    = $clog2(REQ_NUM)
) (
   input  logic [REQ_NUM-1:0] eligible,
   input  logic [ID_W-1:0]    rr_ptr,
   output logic [REQ_NUM-1:0] grant,
   output logic [ID_W-1:0]    winner
);

   logic found;
   int   idx;

   always_comb begin
      grant  = '0;
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      for (int off = 0; off < REQ_NUM; off++) begin
         idx = (int'(rr_ptr) + off) % REQ_NUM;
         if (!found && eligible[idx]) begin
            found       = 1'b1;
            grant[idx]  = 1'b1;
            winner      = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/msrh_l2_req_arbiter.sv
// msrh_l2_req_arbiter: shares the single L2 request port among the tile's
// L2 clients (0 = ICache, 1 = L1D, 2 = PTW).
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   bus (slave)      : client request/response channels and L2 port
// One eligible client is picked per cycle in round-robin order and held in a
// registered output stage until L2 accepts it. The requester ID is prepended
// to the outgoing tag; L2 responses are routed back combinationally by that
// ID. Each client's outstanding requests are counted and capped at MAX_OUTST.
// Optional feature macro: MSRH_L2_ARB_PERF_EN enables per-client 32-bit grant
// counters on o_perf_grant_cnt; without it that output is tied to zero.
module msrh_l2_req_arbiter
   import msrh_pkg::*;
#(
   parameter int REQ_NUM   = 3,
   parameter int ADDR_W    = 56,
   parameter int DATA_W    = 512,
   parameter int TAG_W     = 4,
   parameter int MAX_OUTST = 4
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   msrh_l2_req_arbiter_if.slave  bus
);

   localparam int ID_W  = $clog2(REQ_NUM);
   localparam int CNT_W = $clog2(MAX_OUTST + 1);

   logic [REQ_NUM-1:0]    elig;
   logic [REQ_NUM-1:0]    grant;
   logic [ID_W-1:0]       winner;
   logic [ID_W-1:0]       rr_ptr;
   logic                  load_ok;
   logic                  accept;
   logic [REQ_NUM-1:0]    req_ready;
   logic [REQ_NUM-1:0]    inc;
   logic [REQ_NUM-1:0]    dec;
   logic [REQ_NUM-1:0]    resp_hit;
   logic [ID_W-1:0]       resp_id;
   logic [CNT_W-1:0]      outst_cnt [REQ_NUM];

   logic                  vld_p1;
   l2_cmd_t               cmd_p1;
   logic [ADDR_W-1:0]     addr_p1;
   logic [DATA_W-1:0]     data_p1;
   logic [ID_W+TAG_W-1:0] tag_p1;

   assign resp_id = bus.i_l2_resp_tag[ID_W+TAG_W-1:TAG_W];

   // An unknown ID (>= REQ_NUM) matches no requester, so it is dropped and
   // leaves all counters alone. A decrement at zero is suppressed.
   always_comb begin
      elig     = '0;
      inc      = '0;
      dec      = '0;
      resp_hit = '0;
      for (int i = 0; i < REQ_NUM; i++) begin
         elig[i]     = bus.i_req_valid[i] && (outst_cnt[i] < CNT_W'(MAX_OUTST));
         inc[i]      = accept && grant[i];
         resp_hit[i] = bus.i_l2_resp_valid && (resp_id == ID_W'(i));
         dec[i]      = resp_hit[i] && (outst_cnt[i] != '0);
      end
   end

   msrh_rr_arbiter #(
      .REQ_NUM (REQ_NUM)
   ) u_rr_arbiter (
      .eligible (elig),
      .rr_ptr   (rr_ptr),
      .grant    (grant),
      .winner   (winner)
   );

   // The output stage can take a new request when empty or draining this
   // cycle, which gives back-to-back throughput.
   assign load_ok   = !vld_p1 || bus.i_l2_req_ready;
   assign req_ready = (i_reset_n && load_ok) ? grant : '0;
   assign accept    = |req_ready;

   assign bus.o_req_ready = req_ready;

   // ---- stage p1: registered L2 request ----
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         vld_p1  <= 1'b0;
         cmd_p1  <= LOAD;
         addr_p1 <= '0;
         data_p1 <= '0;
         tag_p1  <= '0;
         rr_ptr  <= '0;
      end else if (accept) begin
         vld_p1  <= 1'b1;
         cmd_p1  <= l2_cmd_t'(bus.i_req_cmd[winner]);
         addr_p1 <= bus.i_req_addr[winner];
         data_p1 <= bus.i_req_data[winner];
         tag_p1  <= {winner, bus.i_req_tag[winner]};
         rr_ptr  <= ID_W'(rr_next(int'(winner), REQ_NUM));
      end else if (bus.i_l2_req_ready) begin
         vld_p1  <= 1'b0;
      end
   end

   assign bus.o_l2_req_valid = vld_p1;
   assign bus.o_l2_req_cmd   = cmd_p1;
   assign bus.o_l2_req_addr  = addr_p1;
   assign bus.o_l2_req_data  = data_p1;
   assign bus.o_l2_req_tag   = tag_p1;

   // Simultaneous accept and response for the same client cancel out.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int i = 0; i < REQ_NUM; i++) outst_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < REQ_NUM; i++) begin
            if (inc[i] && !dec[i])      outst_cnt[i] <= outst_cnt[i] + 1'b1;
            else if (dec[i] && !inc[i]) outst_cnt[i] <= outst_cnt[i] - 1'b1;
         end
      end
   end

   assign bus.o_resp_valid = resp_hit;
   assign bus.o_resp_tag   = bus.i_l2_resp_tag[TAG_W-1:0];
   assign bus.o_resp_data  = bus.i_l2_resp_data;

`ifdef MSRH_L2_ARB_PERF_EN
   logic [REQ_NUM-1:0][31:0] perf_cnt;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         perf_cnt <= '0;
      end else begin
         for (int i = 0; i < REQ_NUM; i++) begin
            if (inc[i]) perf_cnt[i] <= perf_cnt[i] + 32'd1;
         end
      end
   end

   assign bus.o_perf_grant_cnt = perf_cnt;
`else
   assign bus.o_perf_grant_cnt = '0;
`endif

`ifndef SYNTHESIS
   // Responses must carry a known ID and belong to an outstanding request.
   always @(posedge i_clk) begin
      if (i_reset_n && bus.i_l2_resp_valid) begin
         assert (int'(resp_id) < REQ_NUM);
         if (int'(resp_id) < REQ_NUM) assert (outst_cnt[resp_id] != '0);
      end
   end
`endif

endmodule

// File: tb/tb_msrh_l2_req_arbiter.sv
// tb_msrh_l2_req_arbiter: directed scoreboard bench for msrh_l2_req_arbiter.
// Expected L2 requests and client responses are queued when stimulus is
// issued; a negedge monitor pops and compares them whenever the DUT presents
// an L2 handshake or a routed response.
module tb_msrh_l2_req_arbiter;
   import msrh_pkg::*;

   localparam int REQ_NUM = 3;
   localparam int ADDR_W  = 56;
   localparam int DATA_W  = 512;
   localparam int TAG_W   = 4;
   localparam int ID_W    = 2;

   typedef struct packed {
      logic [1:0]            cmd;
      logic [ADDR_W-1:0]     addr;
      logic [DATA_W-1:0]     data;
      logic [ID_W+TAG_W-1:0] tag;
   } req_t;

   typedef struct packed {
      logic [REQ_NUM-1:0] vld;
      logic [TAG_W-1:0]   tag;
      logic [DATA_W-1:0]  data;
   } rsp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;
   req_t req_q[$];
   rsp_t rsp_q[$];
   req_t mon_req;
   rsp_t mon_rsp;

   always #5 clk = ~clk;

   msrh_l2_req_arbiter_if #(
      .REQ_NUM (REQ_NUM), .ADDR_W (ADDR_W), .DATA_W (DATA_W), .TAG_W (TAG_W)
   ) bus ();

   msrh_l2_req_arbiter #(
      .REQ_NUM (REQ_NUM), .ADDR_W (ADDR_W), .DATA_W (DATA_W), .TAG_W (TAG_W),
      .MAX_OUTST (4)
   ) dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .bus       (bus)
   );

   task automatic chk(input string name, input logic [DATA_W-1:0] act,
                      input logic [DATA_W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [ADDR_W-1:0] mk_addr(input int id, input int tag);
      return 56'hA000_0000 + ADDR_W'(id * 4096) + ADDR_W'(tag * 64);
   endfunction

   function automatic logic [DATA_W-1:0] mk_data(input int id, input int tag);
      return {16{8'(id), 8'(tag), 16'hC0DE}};
   endfunction

   function automatic logic [DATA_W-1:0] mk_rdata(input int id, input int tag);
      return {16{16'hBEEF, 8'(id), 8'(tag)}};
   endfunction

   function automatic logic [1:0] mk_cmd(input int tag);
      return 2'(tag % 3);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input int id, input int tag);
      bus.i_req_valid[id] = 1'b1;
      bus.i_req_tag[id]   = TAG_W'(tag);
      bus.i_req_cmd[id]   = mk_cmd(tag);
      bus.i_req_addr[id]  = mk_addr(id, tag);
      bus.i_req_data[id]  = mk_data(id, tag);
   endtask

   task automatic expect_req(input int id, input int tag);
      req_t e;
      e.cmd  = mk_cmd(tag);
      e.addr = mk_addr(id, tag);
      e.data = mk_data(id, tag);
      e.tag  = {ID_W'(id), TAG_W'(tag)};
      req_q.push_back(e);
   endtask

   task automatic send_resp(input int id, input int tag);
      rsp_t e;
      bus.i_l2_resp_valid = 1'b1;
      bus.i_l2_resp_tag   = {ID_W'(id), TAG_W'(tag)};
      bus.i_l2_resp_data  = mk_rdata(id, tag);
      e.vld  = REQ_NUM'(1 << id);
      e.tag  = TAG_W'(tag);
      e.data = mk_rdata(id, tag);
      rsp_q.push_back(e);
   endtask

   // Monitor: an L2 handshake completes at the next posedge when valid and
   // ready are both high here; routed responses are combinational.
   always @(negedge clk) begin
      if (rst_n && bus.o_l2_req_valid && bus.i_l2_req_ready) begin
         if (req_q.size() == 0) begin
            chk("l2_req_unexpected", bus.o_l2_req_tag, '1);
         end else begin
            mon_req = req_q.pop_front();
            chk("l2_req_tag",  bus.o_l2_req_tag,  mon_req.tag);
            chk("l2_req_cmd",  bus.o_l2_req_cmd,  mon_req.cmd);
            chk("l2_req_addr", bus.o_l2_req_addr, mon_req.addr);
            chk("l2_req_data", bus.o_l2_req_data, mon_req.data);
         end
      end
      if (rst_n && bus.i_l2_resp_valid) begin
         if (rsp_q.size() == 0) begin
            chk("resp_unexpected", bus.o_resp_valid, '0);
         end else begin
            mon_rsp = rsp_q.pop_front();
            chk("resp_valid", bus.o_resp_valid, mon_rsp.vld);
            chk("resp_tag",   bus.o_resp_tag,   mon_rsp.tag);
            chk("resp_data",  bus.o_resp_data,  mon_rsp.data);
         end
      end
   end

   initial begin
      bus.i_req_valid     = '0;
      bus.i_req_cmd       = '0;
      bus.i_req_addr      = '0;
      bus.i_req_tag       = '0;
      bus.i_req_data      = '0;
      bus.i_l2_req_ready  = 1'b0;
      bus.i_l2_resp_valid = 1'b0;
      bus.i_l2_resp_tag   = '0;
      bus.i_l2_resp_data  = '0;

      // Reset state, with all requesters asking.
      drive_req(0, 1); drive_req(1, 1); drive_req(2, 1);
      bus.i_l2_req_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_l2_valid", bus.o_l2_req_valid, 0);
      chk("rst_req_ready", bus.o_req_ready, 0);
      chk("rst_l2_addr", bus.o_l2_req_addr, 0);
      chk("rst_l2_tag", bus.o_l2_req_tag, 0);
      chk("rst_perf", bus.o_perf_grant_cnt, 0);
      bus.i_req_valid = '0;
      tick();
      rst_n = 1'b1;
      tick();

      // Single requester: ICache tag 3.
      drive_req(L2_REQ_IC, 3);
      expect_req(0, 3);
      @(negedge clk);
      chk("single_ready", bus.o_req_ready, 3'b001);
      tick();
      bus.i_req_valid[0] = 1'b0;
      @(negedge clk);
      chk("single_latency", bus.o_l2_req_valid, 1);
      tick();
      send_resp(0, 3);
      tick();
      bus.i_l2_resp_valid = 1'b0;

      // Fairness: pointer sits at 1 after the ICache grant.
      drive_req(0, 4); drive_req(1, 5); drive_req(2, 6);
      expect_req(1, 5); expect_req(2, 6); expect_req(0, 4);
      expect_req(1, 5); expect_req(2, 6); expect_req(0, 4);
      repeat (6) @(posedge clk);
      #1;
      bus.i_req_valid = '0;
      @(negedge clk);
`ifdef MSRH_L2_ARB_PERF_EN
      chk("perf_ic",  bus.o_perf_grant_cnt[0], 3);
      chk("perf_l1d", bus.o_perf_grant_cnt[1], 2);
      chk("perf_ptw", bus.o_perf_grant_cnt[2], 2);
`else
      chk("perf_tied", bus.o_perf_grant_cnt, 0);
`endif
      tick();
      for (int r = 0; r < 2; r++) begin
         send_resp(1, 5); tick();
         send_resp(2, 6); tick();
         send_resp(0, 4); tick();
      end
      bus.i_l2_resp_valid = 1'b0;

      // Backpressure.
      bus.i_l2_req_ready = 1'b0;
      drive_req(2, 9);
      expect_req(2, 9);
      tick();
      bus.i_req_valid[2] = 1'b0;
      drive_req(1, 10);
      expect_req(1, 10);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_ready", bus.o_req_ready, 0);
         chk("bp_valid", bus.o_l2_req_valid, 1);
         chk("bp_addr", bus.o_l2_req_addr, mk_addr(2, 9));
         chk("bp_tag", bus.o_l2_req_tag, {2'd2, 4'd9});
      end
      tick();
      bus.i_l2_req_ready = 1'b1;
      @(negedge clk);
      chk("bp_same_cycle_ready", bus.o_req_ready, 3'b010);
      tick();
      bus.i_req_valid[1] = 1'b0;
      tick();
      send_resp(2, 9); tick();
      send_resp(1, 10); tick();
      bus.i_l2_resp_valid = 1'b0;

      // Cap: four L1D requests with no responses.
      for (int k = 0; k < 4; k++) begin
         drive_req(1, k);
         expect_req(1, k);
         tick();
      end
      drive_req(1, 4);
      @(negedge clk);
      chk("cap_block", bus.o_req_ready, 0);
      tick();
      drive_req(2, 11);
      expect_req(2, 11);
      @(negedge clk);
      chk("cap_ptw_granted", bus.o_req_ready, 3'b100);
      tick();
      bus.i_req_valid[2] = 1'b0;
      send_resp(1, 0);
      @(negedge clk);
      chk("cap_resp_cycle", bus.o_req_ready, 0);
      tick();
      bus.i_l2_resp_valid = 1'b0;
      expect_req(1, 4);
      @(negedge clk);
      chk("cap_release", bus.o_req_ready, 3'b010);
      tick();
      bus.i_req_valid[1] = 1'b0;

      // Same-cycle accept and response on L1D (count 3 before, 3 after).
      send_resp(1, 1);
      tick();
      drive_req(1, 5);
      send_resp(1, 2);
      expect_req(1, 5);
      @(negedge clk);
      chk("same_accept", bus.o_req_ready, 3'b010);
      tick();
      bus.i_l2_resp_valid = 1'b0;
      drive_req(1, 6);
      expect_req(1, 6);
      @(negedge clk);
      chk("same_cycle_cnt", bus.o_req_ready, 3'b010);
      tick();
      drive_req(1, 7);
      @(negedge clk);
      chk("same_cycle_capped", bus.o_req_ready, 0);
      tick();
      bus.i_req_valid[1] = 1'b0;

      // Reset while a request is held by L2 backpressure.
      bus.i_l2_req_ready = 1'b0;
      drive_req(0, 2);
      tick();
      @(negedge clk);
      chk("held_valid", bus.o_l2_req_valid, 1);
      tick();
      drive_req(2, 2);
      rst_n = 1'b0;
      #1;
      chk("midrst_l2_valid", bus.o_l2_req_valid, 0);
      chk("midrst_req_ready", bus.o_req_ready, 0);
      chk("midrst_tag", bus.o_l2_req_tag, 0);
      tick();
      bus.i_req_valid = '0;
      bus.i_l2_req_ready = 1'b1;
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_l2_valid", bus.o_l2_req_valid, 0);
      chk("post_rst_perf", bus.o_perf_grant_cnt, 0);
      tick();
      // Pointer back at 0 and L1D count cleared: order 0, 1, 2.
      drive_req(0, 1); drive_req(1, 2); drive_req(2, 3);
      expect_req(0, 1); expect_req(1, 2); expect_req(2, 3);
      @(negedge clk);
      chk("post_rst_first_grant", bus.o_req_ready, 3'b001);
      repeat (3) @(posedge clk);
      #1;
      bus.i_req_valid = '0;

      for (int i = 0; i < 20 && (req_q.size() != 0 || rsp_q.size() != 0); i++)
         @(negedge clk);
      @(negedge clk);
      chk("queues_drained", req_q.size() + rsp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/msrh_l2_req_arbiter.md
# msrh_l2_req_arbiter

Shares the single L2 request port among the tile's L2 clients: ICache refill, L1D miss/eviction, and PTW walk. It selects one client per cycle with round-robin arbitration and holds the selection in a registered output stage until L2 accepts it. The requester ID is appended to the outgoing tag so that L2 responses can be routed back to the right client. Each client's outstanding requests are counted and capped. The block sits between the tile-level L2 request/response interfaces and the external L2.

## Interface
- REQ_NUM, 3, number of requesters (index 0 = ICache, 1 = L1D, 2 = PTW)
- ADDR_W, 56, physical address width
- DATA_W, 512, request/response data width (one cache line)
- TAG_W, 4, requester-local tag width
- MAX_OUTST, 4, maximum outstanding requests per requester
- ID_W (derived), $clog2(REQ_NUM), requester-ID field width
- i_clk  in  1  clock; single clock domain
- i_reset_n  in  1  reset; asynchronous, active-low
- i_req_valid  in  REQ_NUM  per-requester request valid
- o_req_ready  out  REQ_NUM  per-requester accept
- i_req_cmd  in  REQ_NUM×2  per-requester command (LOAD, STORE, EVICT)
- i_req_addr  in  REQ_NUM×ADDR_W  per-requester address
- i_req_tag  in  REQ_NUM×TAG_W  per-requester tag
- i_req_data  in  REQ_NUM×DATA_W  per-requester write data
- o_l2_req_valid  out  1  L2 request valid
- i_l2_req_ready  in  1  L2 accept
- o_l2_req_cmd / o_l2_req_addr / o_l2_req_data  out  2 / ADDR_W / DATA_W  payload of the selected request
- o_l2_req_tag  out  ID_W+TAG_W  tag sent to L2: {requester ID, local tag}
- i_l2_resp_valid  in  1  L2 response valid; always accepted, no backpressure
- i_l2_resp_tag  in  ID_W+TAG_W  response tag
- i_l2_resp_data  in  DATA_W  response data
- o_resp_valid  out  REQ_NUM  one-hot response valid to the owning requester
- o_resp_tag  out  TAG_W  local tag, taken from i_l2_resp_tag[TAG_W-1:0]
- o_resp_data  out  DATA_W  response data, shared by all requesters
- o_perf_grant_cnt  out  REQ_NUM×32  per-requester grant counters (see Configuration)

## Operation
- Requester i is eligible when i_req_valid[i] is high and outst_cnt[i] < MAX_OUTST.
- Round-robin arbitration starts the search at pointer rr_ptr and picks the first eligible requester, giving winner w.
- o_req_ready[w] = 1 only when the output stage can load, i.e. !out_valid || i_l2_req_ready. All other o_req_ready bits are 0.
- When a request is accepted, the output register captures {cmd, addr, data, {w, tag}}, out_valid becomes 1, and rr_ptr becomes (w+1) mod REQ_NUM.
- While out_valid && !i_l2_req_ready, the payload is held stable and no new request is accepted.
- outst_cnt[i] increments when requester i's request is accepted. It decrements when i_l2_resp_valid is high and i_l2_resp_tag[ID_W+TAG_W-1:TAG_W] == i.
- If an increment and a decrement hit the same requester in the same cycle, the count is unchanged.
- Responses are combinational pass-through: o_resp_valid[id] = i_l2_resp_valid.
- A response whose ID ≥ REQ_NUM is dropped and does not change any counter. A simulation assertion fires on this case.
- A response arriving while outst_cnt[id] == 0 triggers a simulation assertion. The counter saturates at 0.

## Timing
- Request latency: accepted in cycle N, o_l2_req_valid is high in cycle N+1.
- Back-to-back: a new request can be accepted in the same cycle that L2 accepts the current one, giving full throughput.
- Response latency: 0 cycles (combinational).
- A requester blocked by its cap becomes eligible again in the cycle after the freeing response arrives.
- Reset values: out_valid=0, rr_ptr=0, all outst_cnt=0, perf counters=0.
- Reset outputs: o_l2_req_valid=0, o_req_ready=0 while i_reset_n is low, payload outputs=0.
- Reset asserted mid-operation discards any held request immediately; recovery of outstanding L2 transactions is the system's responsibility.

## Configuration
- MSRH_L2_ARB_PERF_EN defined: per-requester 32-bit grant counters increment on each accept, wrap at 2^32, reset to 0, and drive o_perf_grant_cnt.
- MSRH_L2_ARB_PERF_EN undefined: no counters are instantiated and o_perf_grant_cnt is tied to 0.

## Structure
- The l2_cmd_t enum (LOAD=0, STORE=1, EVICT=2) and the requester index constants L2_REQ_IC, L2_REQ_L1D, L2_REQ_PTW belong in msrh_pkg.
- Sub-module msrh_rr_arbiter (parameter REQ_NUM): inputs are the eligible vector and rr_ptr; outputs are a one-hot grant and an encoded winner. It is purely combinational; the pointer register stays in the parent.

## Test plan
- Single requester: ICache issues tag 3 with i_l2_req_ready=1 → o_l2_req_valid the next cycle with o_l2_req_tag={0,3}. A response with tag {0,3} → o_resp_valid=3'b001, o_resp_tag=3.
- Fairness: all three requesters valid continuously with L2 always ready → grant order 0, 1, 2, 0, 1, 2; perf counters equal after 30 cycles (PERF_EN build).
- Backpressure: i_l2_req_ready=0 for 5 cycles → payload stable and o_req_ready=0; ready rises → the next request is accepted in that same cycle.
- Cap: L1D issues 4 requests with no responses → 5th held off with o_req_ready[1]=0 while PTW is still granted; one L1D response → L1D is granted the following cycle.
- Same-cycle events: an L1D accept and an L1D response in the same cycle → outst_cnt[1] unchanged.
- Reset: assert i_reset_n=0 while a request is held → o_l2_req_valid=0 immediately and all counters are 0 after release.
